// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the RV32I front end.
//   XLEN             : architectural register / address width
//   DEFAULT_RESET_PC : PC value loaded on reset
//   fetch_state_t    : fetch controller FSM states
//   pc_incr()        : sequential next-PC (wraps modulo 2^32)
// ---------------------------------------------------------------------------
package core_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StWait  = 2'd2,
      StFull  = 2'd3
   } fetch_state_t;

   function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/target_adder.sv
// ---------------------------------------------------------------------------
// target_adder
// Combinational jump/branch target generator, shared with the branch unit.
//   i_base     : jump base (PC for JAL/branches, rs1 for JALR)
//   i_imm      : sign-extended offset
//   i_jalr     : clear bit 0 of the sum (JALR semantics)
//   o_target   : (base + imm) mod 2^32, bit 0 cleared when i_jalr
//   o_misalign : target is not 4-byte aligned
// ---------------------------------------------------------------------------
module target_adder
   import core_pkg::*;
(
   input  logic [XLEN-1:0] i_base,
   input  logic [XLEN-1:0] i_imm,
   input  logic            i_jalr,
   output logic [XLEN-1:0] o_target,
   output logic            o_misalign
);

   logic [XLEN-1:0] w_sum;

   assign w_sum      = i_base + i_imm;
   assign o_target   = {w_sum[XLEN-1:1], w_sum[0] & ~i_jalr};
   // Misalignment is judged after the JALR bit-0 clear.
   assign o_misalign = |o_target[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// PC register and single-outstanding instruction-fetch controller.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_base, i_imm       : redirect target operands
//   i_jump_valid, i_jalr: redirect request / JALR qualifier
//   o_imem_req/addr     : fetch request to instruction memory
//   i_imem_rvalid/rdata : fetch response
//   o_if_valid/pc/instr : instruction buffer towards decode
//   i_if_ready          : decode accepts the buffer
//   o_misalign_exc/addr : misaligned redirect target report (one-cycle pulse)
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [XLEN-1:0] i_base,
   input  logic [XLEN-1:0] i_imm,
   input  logic            i_jump_valid,
   input  logic            i_jalr,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic            o_if_valid,
   output logic [XLEN-1:0] o_if_pc,
   output logic [XLEN-1:0] o_if_instr,
   input  logic            i_if_ready,
   output logic            o_misalign_exc,
   output logic [XLEN-1:0] o_misalign_addr
);

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic            r_kill;
   logic            w_kill_nxt;
   logic            r_if_valid;
   logic            w_if_valid_nxt;
   logic [XLEN-1:0] r_if_pc;
   logic [XLEN-1:0] w_if_pc_nxt;
   logic [XLEN-1:0] r_if_instr;
   logic [XLEN-1:0] w_if_instr_nxt;
   logic            r_misalign_exc;
   logic            w_misalign_exc_nxt;
   logic [XLEN-1:0] r_misalign_addr;
   logic [XLEN-1:0] w_misalign_addr_nxt;

   logic [XLEN-1:0] w_target;
   logic            w_misalign;
   logic            w_redirect;
   logic            w_bad_jump;

   target_adder u_target_adder (
      .i_base     (i_base),
      .i_imm      (i_imm),
      .i_jalr     (i_jalr),
      .o_target   (w_target),
      .o_misalign (w_misalign)
   );

   // A misaligned target never redirects; it only raises the exception pulse.
   assign w_redirect = i_jump_valid & ~w_misalign;
   assign w_bad_jump = i_jump_valid & w_misalign;

   always_comb begin
      w_state_nxt         = r_state;
      w_pc_nxt            = r_pc;
      w_kill_nxt          = r_kill;
      w_if_valid_nxt      = r_if_valid;
      w_if_pc_nxt         = r_if_pc;
      w_if_instr_nxt      = r_if_instr;
      w_misalign_exc_nxt  = w_bad_jump;
      w_misalign_addr_nxt = w_bad_jump ? w_target : r_misalign_addr;
      o_imem_req          = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_state_nxt = StFetch;
            if (w_redirect) begin
               w_pc_nxt = w_target;
            end
         end

         StFetch: begin
            o_imem_req  = 1'b1;
            w_state_nxt = StWait;
            // The request going out this cycle is on the wrong path.
            if (w_redirect) begin
               w_pc_nxt   = w_target;
               w_kill_nxt = 1'b1;
            end
         end

         StWait: begin
            if (w_redirect) begin
               w_pc_nxt = w_target;
               if (i_imem_rvalid) begin
                  // Response arriving with the redirect is stale: drop it now.
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = StFetch;
               end else begin
                  w_kill_nxt = 1'b1;
               end
            end else if (i_imem_rvalid) begin
               if (r_kill) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = StFetch;
               end else begin
                  w_if_valid_nxt = 1'b1;
                  w_if_pc_nxt    = r_pc;
                  w_if_instr_nxt = i_imem_rdata;
                  w_pc_nxt       = pc_incr(r_pc);
                  w_state_nxt    = StFull;
               end
            end
         end

         StFull: begin
            // Redirect takes priority over decode accepting the buffer.
            if (w_redirect) begin
               w_pc_nxt       = w_target;
               w_if_valid_nxt = 1'b0;
               w_state_nxt    = StFetch;
            end else if (i_if_ready) begin
               w_if_valid_nxt = 1'b0;
               w_state_nxt    = StFetch;
            end
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= StIdle;
         r_pc            <= RESET_PC;
         r_kill          <= 1'b0;
         r_if_valid      <= 1'b0;
         r_if_pc         <= '0;
         r_if_instr      <= '0;
         r_misalign_exc  <= 1'b0;
         r_misalign_addr <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_pc            <= w_pc_nxt;
         r_kill          <= w_kill_nxt;
         r_if_valid      <= w_if_valid_nxt;
         r_if_pc         <= w_if_pc_nxt;
         r_if_instr      <= w_if_instr_nxt;
         r_misalign_exc  <= w_misalign_exc_nxt;
         r_misalign_addr <= w_misalign_addr_nxt;
      end
   end

   assign o_imem_addr     = r_pc;
   assign o_if_valid      = r_if_valid;
   assign o_if_pc         = r_if_pc;
   assign o_if_instr      = r_if_instr;
   assign o_misalign_exc  = r_misalign_exc;
   assign o_misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed bench for pc_fetch_ctrl with a latency-programmable memory model.
// Memory returns {addr[23:0], 8'h13} for a request to addr.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] base;
   logic [31:0] imm;
   logic        jump_valid;
   logic        jalr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        misalign_exc;
   logic [31:0] misalign_addr;

   int n_checks = 0;
   int n_fails  = 0;

   // memory model state
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic        mem_pend = 1'b0;
   logic [31:0] mem_paddr = '0;
   logic        req_s;
   logic [31:0] addr_s;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_base          (base),
      .i_imm           (imm),
      .i_jump_valid    (jump_valid),
      .i_jalr          (jalr),
      .o_imem_req      (imem_req),
      .o_imem_addr     (imem_addr),
      .i_imem_rvalid   (imem_rvalid),
      .i_imem_rdata    (imem_rdata),
      .o_if_valid      (if_valid),
      .o_if_pc         (if_pc),
      .o_if_instr      (if_instr),
      .i_if_ready      (if_ready),
      .o_misalign_exc  (misalign_exc),
      .o_misalign_addr (misalign_addr)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   // Response appears k cycles after the cycle the request was presented.
   // A pending response deliberately survives DUT reset.
   always @(posedge clk) begin
      req_s  = imem_req;
      addr_s = imem_addr;
      #1;
      imem_rvalid = 1'b0;
      if (req_s) begin
         mem_pend  = 1'b1;
         mem_cnt   = mem_lat;
         mem_paddr = addr_s;
      end
      if (mem_pend) begin
         mem_cnt = mem_cnt - 1;
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_paddr);
            mem_pend    = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (if_valid) break;
         step();
      end
      check(tag, {31'd0, if_valid}, 32'd1);
   endtask

   initial begin
      rst_n       = 1'b0;
      base        = '0;
      imm         = '0;
      jump_valid  = 1'b0;
      jalr        = 1'b0;
      if_ready    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;

      // reset state
      step();
      step();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_ifv", {31'd0, if_valid}, 32'd0);
      check("rst_ifpc", if_pc, 32'h0);
      check("rst_ifinstr", if_instr, 32'h0);
      check("rst_mexc", {31'd0, misalign_exc}, 32'd0);
      check("rst_maddr", misalign_addr, 32'h0);

      // first fetch, k=1
      rst_n = 1'b1;                       // cycle 1: IDLE
      step();                             // cycle 2: FETCH
      check("f0_req", {31'd0, imem_req}, 32'd1);
      check("f0_addr", imem_addr, 32'h0);
      step();                             // cycle 3: WAIT
      check("f0_wait_req", {31'd0, imem_req}, 32'd0);
      step();                             // cycle 4: FULL
      check("f0_ifv", {31'd0, if_valid}, 32'd1);
      check("f0_ifpc", if_pc, 32'h0);
      check("f0_instr", if_instr, 32'h13);

      // stall in FULL
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_ifv", {31'd0, if_valid}, 32'd1);
         check("stall_ifpc", if_pc, 32'h0);
         check("stall_instr", if_instr, 32'h13);
         check("stall_req", {31'd0, imem_req}, 32'd0);
      end

      if_ready = 1'b1;
      step();
      if_ready = 1'b0;
      check("f1_req", {31'd0, imem_req}, 32'd1);
      check("f1_addr", imem_addr, 32'h4);
      check("f1_ifv", {31'd0, if_valid}, 32'd0);
      step();
      step();
      check("f1_ifpc", if_pc, 32'h4);
      check("f1_instr", if_instr, 32'h413);
      if_ready = 1'b1;
      step();
      if_ready = 1'b0;
      check("f2_addr", imem_addr, 32'h8);
      check("f2_req", {31'd0, imem_req}, 32'd1);

      // redirect in WAIT, k=3
      mem_lat = 3;
      step();                             // WAIT (N+1)
      jump_valid = 1'b1;
      base       = 32'h100;
      imm        = 32'h20;
      step();                             // WAIT (N+2), kill set
      jump_valid = 1'b0;
      check("rw_ifv_a", {31'd0, if_valid}, 32'd0);
      check("rw_req_a", {31'd0, imem_req}, 32'd0);
      step();                             // WAIT (N+3), stale response
      check("rw_ifv_b", {31'd0, if_valid}, 32'd0);
      step();                             // FETCH at target
      check("rw_req", {31'd0, imem_req}, 32'd1);
      check("rw_addr", imem_addr, 32'h120);
      check("rw_ifv_c", {31'd0, if_valid}, 32'd0);
      step();
      wait_valid("rw_valid");
      check("rw_ifpc", if_pc, 32'h120);
      check("rw_instr", if_instr, 32'h12013);
      mem_lat = 1;

      // misaligned JALR target in FULL
      jalr       = 1'b1;
      base       = 32'h203;
      imm        = 32'h0;
      jump_valid = 1'b1;
      step();
      jump_valid = 1'b0;
      check("mis_exc", {31'd0, misalign_exc}, 32'd1);
      check("mis_addr", misalign_addr, 32'h202);
      check("mis_ifv", {31'd0, if_valid}, 32'd1);
      check("mis_ifpc", if_pc, 32'h120);
      check("mis_req", {31'd0, imem_req}, 32'd0);
      check("mis_pc", imem_addr, 32'h124);
      step();
      check("mis_pulse", {31'd0, misalign_exc}, 32'd0);

      // aligned JALR target, redirect beats if_ready
      base       = 32'h201;
      jump_valid = 1'b1;
      if_ready   = 1'b1;
      step();
      jump_valid = 1'b0;
      if_ready   = 1'b0;
      jalr       = 1'b0;
      check("jalr_req", {31'd0, imem_req}, 32'd1);
      check("jalr_addr", imem_addr, 32'h200);
      check("jalr_ifv", {31'd0, if_valid}, 32'd0);
      check("jalr_noexc", {31'd0, misalign_exc}, 32'd0);
      step();
      step();
      check("jalr_ifpc", if_pc, 32'h200);
      check("jalr_instr", if_instr, 32'h20013);

      // PC wrap
      base       = 32'hFFFF_FFF0;
      imm        = 32'hC;
      jump_valid = 1'b1;
      step();
      jump_valid = 1'b0;
      check("wrap_addr_a", imem_addr, 32'hFFFF_FFFC);
      step();
      step();
      check("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
      check("wrap_instr", if_instr, 32'hFFFF_FC13);
      if_ready = 1'b1;
      step();
      if_ready = 1'b0;
      check("wrap_req", {31'd0, imem_req}, 32'd1);
      check("wrap_addr_b", imem_addr, 32'h0);
      step();
      step();
      base       = 32'hFFFF_FFF0;
      imm        = 32'h20;
      jump_valid = 1'b1;
      step();
      jump_valid = 1'b0;
      check("wrap_tgt", imem_addr, 32'h10);
      check("wrap_tgt_req", {31'd0, imem_req}, 32'd1);

      // redirect during FETCH: issued request is wrong-path
      base       = 32'h40;
      imm        = 32'h4;
      jump_valid = 1'b1;
      step();                             // WAIT, killed response this cycle
      jump_valid = 1'b0;
      check("rf_req_a", {31'd0, imem_req}, 32'd0);
      step();
      check("rf_req", {31'd0, imem_req}, 32'd1);
      check("rf_addr", imem_addr, 32'h44);
      check("rf_ifv", {31'd0, if_valid}, 32'd0);
      step();
      step();
      check("rf_ifpc", if_pc, 32'h44);
      check("rf_instr", if_instr, 32'h4413);

      // reset during WAIT, late response after release
      if_ready = 1'b1;
      mem_lat  = 3;
      step();                             // FETCH 0x48
      if_ready = 1'b0;
      check("rr_addr", imem_addr, 32'h48);
      step();                             // WAIT
      rst_n = 1'b0;
      #1;
      check("rr_rst_req", {31'd0, imem_req}, 32'd0);
      check("rr_rst_addr", imem_addr, 32'h0);
      check("rr_rst_ifv", {31'd0, if_valid}, 32'd0);
      check("rr_rst_ifpc", if_pc, 32'h0);
      step();
      rst_n = 1'b1;                       // IDLE
      step();                             // FETCH, stale rvalid high
      check("rr_late_rv", {31'd0, imem_rvalid}, 32'd1);
      check("rr_req", {31'd0, imem_req}, 32'd1);
      check("rr_first", imem_addr, 32'h0);
      step();
      check("rr_ifv_a", {31'd0, if_valid}, 32'd0);
      wait_valid("rr_valid");
      check("rr_ifpc", if_pc, 32'h0);
      check("rr_instr", if_instr, 32'h13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
